// File: rtl/scan_counter_if.sv
// scan_counter_if: groups the scan/count signals of scan_counter.
//   SE       : scan enable (1 = shift, 0 = count), driven by master
//   scan_in  : serial scan data into count[0], driven by master
//   count    : registered counter value, driven by slave
//   scan_out : serial scan data out (count MSB), driven by slave
// master = stimulus side (bench / test controller), slave = the counter.
interface scan_counter_if #(
  parameter int WIDTH = 4
);
  logic             SE;
  logic             scan_in;
  logic [WIDTH-1:0] count;
  logic             scan_out;

  modport master (
    output SE,
    output scan_in,
    input  count,
    input  scan_out
  );

  modport slave (
    input  SE,
    input  scan_in,
    output count,
    output scan_out
  );
endinterface

// File: rtl/scan_counter.sv
// scan_counter: free-running WIDTH-bit up-counter whose register doubles as a
// mux-D scan chain.
//   clk   : single clock, all state changes on its rising edge
//   reset : synchronous, active-low; clears the count with top priority
//   bus   : scan_counter_if.slave
//           SE=1 shifts {count[WIDTH-2:0], scan_in}, SE=0 increments (wraps)
//           count is the register itself, scan_out is a wire from its MSB
module scan_counter #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  scan_counter_if.slave bus
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] shift_next;

  // Shift network: each bit takes its lower neighbour, bit 0 takes scan_in.
  assign shift_next[0] = bus.scan_in;
  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
      assign shift_next[gi] = count_reg[gi-1];
    end
  endgenerate

  // Mode mux in front of the flops; reset is handled in the register process
  // so it overrides both modes.
  always_comb begin
    count_next = count_reg + WIDTH'(1);
    if (bus.SE) begin
      count_next = shift_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // No logic on the outputs: both come straight from the flops.
  assign bus.count    = count_reg;
  assign bus.scan_out = count_reg[WIDTH-1];

endmodule

// File: tb/tb_scan_counter.sv
module tb_scan_counter;

  localparam int WIDTH = 4;

  typedef struct {
    logic [WIDTH-1:0] count;
    logic             so;
    int               tag;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   vec_idx;
  exp_t exp_q[$];

  scan_counter_if #(.WIDTH(WIDTH)) bus ();

  scan_counter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one vector on the falling edge and queue the hand-computed result
  // expected after the following rising edge.
  task automatic drive(input logic r, input logic se, input logic si,
                       input logic [WIDTH-1:0] exp_count, input logic exp_so);
    exp_t e;
    @(negedge clk);
    reset       = r;
    bus.SE      = se;
    bus.scan_in = si;
    e.count = exp_count;
    e.so    = exp_so;
    e.tag   = vec_idx;
    exp_q.push_back(e);
    $display("vec %0d: reset=%0b SE=%0b scan_in=%0b expect count=%b scan_out=%0b",
             vec_idx, r, se, si, exp_count, exp_so);
    vec_idx++;
  endtask

  // Monitor: after every rising edge, compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.count !== e.count) begin
          failures++;
          $display("FAIL count vec %0d: got %b want %b", e.tag, bus.count, e.count);
        end
        checks++;
        if (bus.scan_out !== e.so) begin
          failures++;
          $display("FAIL scan_out vec %0d: got %b want %b", e.tag, bus.scan_out, e.so);
        end
      end
    end
  end

  // Wrap sequence, hand-listed: edges 1..16 after reset.
  logic [WIDTH-1:0] wrap_tab [16];
  logic             wrap_so  [16];

  initial begin
    int waited;
    checks   = 0;
    failures = 0;
    vec_idx  = 0;
    reset       = 1'b1;
    bus.SE      = 1'b0;
    bus.scan_in = 1'b0;

    wrap_tab = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000,
                 4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b0000};
    wrap_so  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset held for two edges: stays cleared.
    drive(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0);

    // Count 5 edges.
    drive(1'b1, 1'b0, 1'b0, 4'b0001, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 4'b0010, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 4'b0011, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 4'b0100, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 4'b0101, 1'b0);

    // Reset mid-count, then full wrap.
    drive(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 1'b0, wrap_tab[i], wrap_so[i]);
    end

    // Reach 0101 again (wrap left it at 0000).
    drive(1'b1, 1'b0, 1'b0, 4'b0001, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 4'b0010, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 4'b0011, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 4'b0100, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 4'b0101, 1'b0);

    // Scan shift 1,0,1,0 from 0101.
    drive(1'b1, 1'b1, 1'b1, 4'b1011, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 4'b0110, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 4'b1101, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 4'b1010, 1'b1);

    // Resume counting from the shifted-in value.
    drive(1'b1, 1'b0, 1'b0, 4'b1011, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 4'b1100, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 4'b1101, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 4'b1110, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 4'b1111, 1'b1);

    // Reset priority during a shift with scan_in=1 held.
    drive(1'b1, 1'b1, 1'b1, 4'b1111, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 4'b0001, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 4'b0011, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 4'b0110, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 4'b1100, 1'b1);

    // Drain the scoreboard, bounded.
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
